// File: rtl/mio_arbiter_if.sv
// Bundle of both master ports plus the shared decoder port of the two-master memory/IO arbiter.
// The arbiter takes the slave side; the masters and the decoder take the master side.
interface mio_arbiter_if;
    logic        m0_req, m0_lock, m0_we, m0_re;
    logic [31:0] m0_a, m0_d;
    logic        m0_ack;
    logic [31:0] m0_q;

    logic        m1_req, m1_lock, m1_we, m1_re;
    logic [31:0] m1_a, m1_d;
    logic        m1_ack;
    logic [31:0] m1_q;

    logic [31:0] mem_a, d_t_mem, d_f_mem;
    logic        wmem, rmem;

    modport slave (
        input  m0_req, m0_lock, m0_we, m0_re, m0_a, m0_d,
        input  m1_req, m1_lock, m1_we, m1_re, m1_a, m1_d,
        input  d_f_mem,
        output m0_ack, m0_q, m1_ack, m1_q,
        output mem_a, d_t_mem, wmem, rmem
    );

    modport master (
        output m0_req, m0_lock, m0_we, m0_re, m0_a, m0_d,
        output m1_req, m1_lock, m1_we, m1_re, m1_a, m1_d,
        output d_f_mem,
        input  m0_ack, m0_q, m1_ack, m1_q,
        input  mem_a, d_t_mem, wmem, rmem
    );
endinterface

// File: rtl/mio_arbiter.sv
// Round-robin arbiter sharing the memory/IO decoder port between the CPU (master 0)
// and a secondary bus master (master 1), with bounded locked bursts.
module mio_arbiter #(
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          clrn,
    mio_arbiter_if.slave  bus,
    output logic [1:0]    owner
);

    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] BCAP = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    state_t        state, state_nx;
    logic          last, last_nx;
    logic [BW-1:0] bcnt, bcnt_nx;

    // last resets to 1 so the CPU wins the very first contention.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            last  <= 1'b1;
            bcnt  <= '0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            bcnt  <= bcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        last_nx  = last;
        bcnt_nx  = bcnt;
        case (state)
            IDLE: begin
                if (bus.m0_req && bus.m1_req)
                    state_nx = last ? G0 : G1;
                else if (bus.m0_req)
                    state_nx = G0;
                else if (bus.m1_req)
                    state_nx = G1;
            end
            G0: begin
                if (bus.m0_req && bus.m0_lock && (bcnt < BCAP)) begin
                    bcnt_nx = bcnt + BW'(1);
                end else begin
                    last_nx = 1'b0;
                    bcnt_nx = '0;
                    if (bus.m1_req)
                        state_nx = G1;
                    else if (bus.m0_req)
                        state_nx = G0;
                    else
                        state_nx = IDLE;
                end
            end
            G1: begin
                if (bus.m1_req && bus.m1_lock && (bcnt < BCAP)) begin
                    bcnt_nx = bcnt + BW'(1);
                end else begin
                    last_nx = 1'b1;
                    bcnt_nx = '0;
                    if (bus.m0_req)
                        state_nx = G0;
                    else if (bus.m1_req)
                        state_nx = G1;
                    else
                        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A simultaneous write and read from one master is treated as a write only.
    always_comb begin
        bus.mem_a   = '0;
        bus.d_t_mem = '0;
        bus.wmem    = 1'b0;
        bus.rmem    = 1'b0;
        bus.m0_ack  = 1'b0;
        bus.m1_ack  = 1'b0;
        case (state)
            G0: begin
                bus.mem_a   = bus.m0_a;
                bus.d_t_mem = bus.m0_d;
                bus.wmem    = bus.m0_req & bus.m0_we;
                bus.rmem    = bus.m0_req & bus.m0_re & ~bus.m0_we;
                bus.m0_ack  = bus.m0_req;
            end
            G1: begin
                bus.mem_a   = bus.m1_a;
                bus.d_t_mem = bus.m1_d;
                bus.wmem    = bus.m1_req & bus.m1_we;
                bus.rmem    = bus.m1_req & bus.m1_re & ~bus.m1_we;
                bus.m1_ack  = bus.m1_req;
            end
            default: ;
        endcase
    end

    assign bus.m0_q = bus.d_f_mem;
    assign bus.m1_q = bus.d_f_mem;
    assign owner    = state;

endmodule

// File: tb/tb_mio_arbiter.sv
// Directed bench for mio_arbiter: a per-cycle vector table, then hand-written
// sequences for the burst cap, async reset mid-burst and reset of the round-robin pointer.
module tb_mio_arbiter;

    logic       clk;
    logic       clrn;
    logic [1:0] owner;
    int         checks;
    int         errors;

    mio_arbiter_if bus ();

    mio_arbiter #(.MAX_BURST(8)) dut (
        .clk   (clk),
        .clrn  (clrn),
        .bus   (bus.slave),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row per clock cycle; ctl = {req, lock, we, re}, flags = {m0_ack, m1_ack, wmem, rmem}.
    typedef struct {
        logic [3:0]  c0;
        logic [31:0] a0, d0;
        logic [3:0]  c1;
        logic [31:0] a1, d1;
        logic [31:0] dfm;
        logic [1:0]  eown;
        logic [3:0]  eflags;
        logic [31:0] ema, edt;
    } vec_t;

    vec_t vecs[15];

    task automatic applyStimulus(input vec_t v);
        {bus.m0_req, bus.m0_lock, bus.m0_we, bus.m0_re} = v.c0;
        bus.m0_a    = v.a0;
        bus.m0_d    = v.d0;
        {bus.m1_req, bus.m1_lock, bus.m1_we, bus.m1_re} = v.c1;
        bus.m1_a    = v.a1;
        bus.m1_d    = v.d1;
        bus.d_f_mem = v.dfm;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %h, expected %h", name, idx, got, exp);
        end
    endtask

    task automatic checkRow(input vec_t v, input int idx);
        checkOutput("owner",   idx, {30'd0, owner},      {30'd0, v.eown});
        checkOutput("m0_ack",  idx, {31'd0, bus.m0_ack}, {31'd0, v.eflags[3]});
        checkOutput("m1_ack",  idx, {31'd0, bus.m1_ack}, {31'd0, v.eflags[2]});
        checkOutput("wmem",    idx, {31'd0, bus.wmem},   {31'd0, v.eflags[1]});
        checkOutput("rmem",    idx, {31'd0, bus.rmem},   {31'd0, v.eflags[0]});
        checkOutput("mem_a",   idx, bus.mem_a,   v.ema);
        checkOutput("d_t_mem", idx, bus.d_t_mem, v.edt);
        checkOutput("m0_q",    idx, bus.m0_q,    v.dfm);
        checkOutput("m1_q",    idx, bus.m1_q,    v.dfm);
    endtask

    task automatic driveIdle();
        vec_t z;
        z = '{4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 2'b00, 4'b0000, 32'h0, 32'h0};
        applyStimulus(z);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0,        32'h0,  32'h0,   2'b00, 4'b0000, 32'h0,        32'h0};
        vecs[1]  = '{4'b1001, 32'h10,       32'h0, 4'b1001, 32'h20,       32'h0,  32'h0,   2'b00, 4'b0000, 32'h0,        32'h0};
        vecs[2]  = '{4'b1001, 32'h10,       32'h0, 4'b1001, 32'h20,       32'h0,  32'h55,  2'b01, 4'b1001, 32'h10,       32'h0};
        vecs[3]  = '{4'b1001, 32'h10,       32'h0, 4'b1001, 32'h20,       32'h0,  32'h66,  2'b10, 4'b0101, 32'h20,       32'h0};
        vecs[4]  = '{4'b1001, 32'h10,       32'h0, 4'b1001, 32'h20,       32'h0,  32'h0,   2'b01, 4'b1001, 32'h10,       32'h0};
        vecs[5]  = '{4'b0000, 32'h0,        32'h0, 4'b1011, 32'hc0000004, 32'h41, 32'h0,   2'b10, 4'b0110, 32'hc0000004, 32'h41};
        vecs[6]  = '{4'b1001, 32'ha0000000, 32'h0, 4'b0000, 32'h0,        32'h0,  32'h17a, 2'b10, 4'b0000, 32'h0,        32'h0};
        vecs[7]  = '{4'b1001, 32'ha0000000, 32'h0, 4'b0000, 32'h0,        32'h0,  32'h17a, 2'b01, 4'b1001, 32'ha0000000, 32'h0};
        vecs[8]  = '{4'b1001, 32'h44,       32'h0, 4'b0000, 32'h0,        32'h0,  32'h0,   2'b01, 4'b1001, 32'h44,       32'h0};
        vecs[9]  = '{4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0,        32'h0,  32'h0,   2'b01, 4'b0000, 32'h0,        32'h0};
        vecs[10] = '{4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0,        32'h0,  32'h0,   2'b00, 4'b0000, 32'h0,        32'h0};
        vecs[11] = '{4'b0000, 32'h0,        32'h0, 4'b1101, 32'h30,       32'h0,  32'h0,   2'b00, 4'b0000, 32'h0,        32'h0};
        vecs[12] = '{4'b0000, 32'h0,        32'h0, 4'b1101, 32'h30,       32'h0,  32'h0,   2'b10, 4'b0101, 32'h30,       32'h0};
        vecs[13] = '{4'b0000, 32'h0,        32'h0, 4'b0101, 32'h30,       32'h0,  32'h0,   2'b10, 4'b0000, 32'h30,       32'h0};
        vecs[14] = '{4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0,        32'h0,  32'h0,   2'b00, 4'b0000, 32'h0,        32'h0};

        // Reset values are visible before any clock edge.
        clrn = 1'b0;
        driveIdle();
        #2;
        checkRow(vecs[0], -1);
        @(negedge clk);
        clrn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkRow(vecs[i], i);
        end

        // Locked burst: m0 write-locked, m1 reading, 12 cycles from IDLE with last=1.
        $display("[TB] locked burst cap");
        for (int c = 0; c < 12; c++) begin
            logic e0, e1;
            @(negedge clk);
            bus.m0_req = 1'b1; bus.m0_lock = 1'b1; bus.m0_we = 1'b1; bus.m0_re = 1'b0;
            bus.m0_a = 32'h7f10; bus.m0_d = 32'(c);
            bus.m1_req = 1'b1; bus.m1_lock = 1'b0; bus.m1_we = 1'b0; bus.m1_re = 1'b1;
            bus.m1_a = 32'h20; bus.m1_d = 32'h0;
            #1;
            e0 = ((c >= 1) && (c <= 8)) || (c >= 10);
            e1 = (c == 9);
            checkOutput("burst_m0_ack", c, {31'd0, bus.m0_ack}, {31'd0, e0});
            checkOutput("burst_m1_ack", c, {31'd0, bus.m1_ack}, {31'd0, e1});
            checkOutput("burst_wmem",   c, {31'd0, bus.wmem},   {31'd0, e0});
            checkOutput("burst_rmem",   c, {31'd0, bus.rmem},   {31'd0, e1});
        end
        @(negedge clk);
        driveIdle();
        @(negedge clk);
        #1;
        checkOutput("burst_release_idle", 0, {30'd0, owner}, 32'd0);

        // Async reset in the middle of a locked burst.
        $display("[TB] async reset mid-burst");
        @(negedge clk);
        bus.m0_req = 1'b1; bus.m0_lock = 1'b1; bus.m0_we = 1'b1;
        bus.m0_a = 32'h7f10; bus.m0_d = 32'h99;
        @(negedge clk);
        #1;
        checkOutput("pre_reset_wmem", 0, {31'd0, bus.wmem}, 32'd1);
        @(negedge clk);
        #1;
        clrn = 1'b0;
        #1;
        checkOutput("rst_owner",  0, {30'd0, owner},      32'd0);
        checkOutput("rst_wmem",   0, {31'd0, bus.wmem},   32'd0);
        checkOutput("rst_m0_ack", 0, {31'd0, bus.m0_ack}, 32'd0);
        checkOutput("rst_mem_a",  0, bus.mem_a,           32'd0);
        driveIdle();
        @(negedge clk);
        clrn = 1'b1;

        // Pointer was 0 before reset; reset must restore 1 so master 0 wins.
        @(negedge clk);
        bus.m0_req = 1'b1; bus.m0_re = 1'b1; bus.m0_a = 32'h10;
        bus.m1_req = 1'b1; bus.m1_re = 1'b1; bus.m1_a = 32'h20;
        #1;
        checkOutput("post_rst_idle", 0, {30'd0, owner}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("post_rst_owner", 0, {30'd0, owner},      32'd1);
        checkOutput("post_rst_m0ack", 0, {31'd0, bus.m0_ack}, 32'd1);
        @(negedge clk);
        driveIdle();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
